// File: rtl/simple_toggle_array_if.sv
// Bus bundle for simple_toggle_array: lane gate operands, shared divide controls and the lane outputs.
// Event-counter signals exist only when SIMPLE_TOGGLE_ARRAY_EVCNT_EN is defined.
interface simple_toggle_array_if #(
    parameter int LANES = 4,
    parameter int DIV_W = 4
);
    logic [LANES-1:0] inp1;
    logic [LANES-1:0] inp2;
    logic             mode;
    logic [DIV_W-1:0] div_val;
    logic [LANES-1:0] out;
`ifdef SIMPLE_TOGGLE_ARRAY_EVCNT_EN
    logic             evcnt_clr;
    logic [15:0]      evcnt;

    modport master (output inp1, output inp2, output mode, output div_val, output evcnt_clr,
                    input out, input evcnt);
    modport slave  (input inp1, input inp2, input mode, input div_val, input evcnt_clr,
                    output out, output evcnt);
`else
    modport master (output inp1, output inp2, output mode, output div_val, input out);
    modport slave  (input inp1, input inp2, input mode, input div_val, output out);
`endif
endinterface

// File: rtl/simple_toggle_array.sv
// Multi-lane gated toggle array with optional per-lane frequency divide and a registered output pipeline.
// Define SIMPLE_TOGGLE_ARRAY_EVCNT_EN to add the saturating rising-edge event counter (evcnt/evcnt_clr).
module simple_toggle_array #(
    parameter int LANES      = 4,
    parameter int OUT_STAGES = 2,
    parameter int DIV_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    simple_toggle_array_if.slave  bus
);

    logic [LANES-1:0] state_bits;
`ifdef SIMPLE_TOGGLE_ARRAY_EVCNT_EN
    logic [LANES-1:0] rise_bits;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic             en;
            logic             state_reg;
            logic             state_next;
            logic [DIV_W-1:0] cnt_reg;
            logic [DIV_W-1:0] cnt_next;

            assign en = bus.inp1[gi] & bus.inp2[gi];

            // cnt defaults to 0, so leaving mode 1 or dropping en always restarts the count.
            always_comb begin
                state_next = state_reg;
                cnt_next   = '0;
                if (!bus.mode) begin
                    state_next = en & ~state_reg;
                end else if (!en) begin
                    state_next = 1'b0;
                end else if (cnt_reg >= bus.div_val) begin
                    state_next = ~state_reg;
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign state_bits[gi] = state_reg;
`ifdef SIMPLE_TOGGLE_ARRAY_EVCNT_EN
            assign rise_bits[gi] = state_next & ~state_reg;
`endif
        end

        if (OUT_STAGES == 0) begin : g_direct
            assign bus.out = state_bits;
        end else begin : g_pipe
            logic [LANES-1:0] pipe_reg [OUT_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < OUT_STAGES; s++) begin
                        pipe_reg[s] <= '0;
                    end
                end else begin
                    pipe_reg[0] <= state_bits;
                    for (int s = 1; s < OUT_STAGES; s++) begin
                        pipe_reg[s] <= pipe_reg[s-1];
                    end
                end
            end

            assign bus.out = pipe_reg[OUT_STAGES-1];
        end
    endgenerate

`ifdef SIMPLE_TOGGLE_ARRAY_EVCNT_EN
    logic [15:0] evcnt_reg;
    logic [15:0] evcnt_next;
    logic [16:0] rise_cnt;
    logic [16:0] evcnt_sum;

    // Rises are taken from the state flops' next value, so evcnt updates on the same edge as state.
    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            rise_cnt = rise_cnt + 17'(rise_bits[i]);
        end
        evcnt_sum = {1'b0, evcnt_reg} + rise_cnt;
        if (bus.evcnt_clr) begin
            evcnt_next = '0;
        end else if (evcnt_sum > 17'h0FFFF) begin
            evcnt_next = 16'hFFFF;
        end else begin
            evcnt_next = evcnt_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evcnt_reg <= '0;
        end else begin
            evcnt_reg <= evcnt_next;
        end
    end

    assign bus.evcnt = evcnt_reg;
`endif

endmodule

// File: tb/tb_simple_toggle_array.sv
// Directed-vector bench for simple_toggle_array (LANES=4, OUT_STAGES=2, DIV_W=4).
// Event-counter scenario runs only when SIMPLE_TOGGLE_ARRAY_EVCNT_EN is defined.
module tb_simple_toggle_array;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    simple_toggle_array_if #(.LANES(4), .DIV_W(4)) bus ();

    simple_toggle_array #(.LANES(4), .OUT_STAGES(2), .DIV_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.inp1    = '0;
        bus.inp2    = '0;
        bus.mode    = 1'b0;
        bus.div_val = '0;
`ifdef SIMPLE_TOGGLE_ARRAY_EVCNT_EN
        bus.evcnt_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.inp1 = 4'hF;
        bus.inp2 = 4'hF;
        #2;
        checks++;
        if (bus.out !== 4'h0) begin
            errors++;
            $display("FAIL reset_hold out=%b expected=%b", bus.out, 4'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.out !== 4'hF) begin
            errors++;
            $display("FAIL reset_prerun out=%b expected=%b", bus.out, 4'hF);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out !== 4'h0) begin
            errors++;
            $display("FAIL reset_async out=%b expected=%b", bus.out, 4'h0);
        end
        bus.inp1 = '0;
        bus.inp2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (bus.out !== 4'h0) begin
                errors++;
                $display("FAIL reset_release n=%0d out=%b expected=%b", n, bus.out, 4'h0);
            end
        end
        $display("test_reset done");
    endtask

    // Lane 0 enabled for edges 1..4, then inp2 dropped.
    task automatic test_legacy();
        logic [8:1] exp_seq;
        logic [3:0] exp_out;
        do_reset();
        exp_seq = 8'b00010100;
        for (int n = 1; n <= 8; n++) begin
            bus.inp1 = 4'b0001;
            bus.inp2 = (n <= 4) ? 4'b0001 : 4'b0000;
            tick();
            exp_out = {3'b000, exp_seq[n]};
            checks++;
            if (bus.out !== exp_out) begin
                errors++;
                $display("FAIL legacy n=%0d out=%b expected=%b", n, bus.out, exp_out);
            end
        end
        $display("test_legacy done");
    endtask

    // Lane 2, div_val=3: enabled edges 1..13, off 14..15, re-enabled from 16.
    task automatic test_divide();
        logic [22:1] exp_seq;
        logic [3:0]  exp_out;
        do_reset();
        exp_seq = 22'b1100000110000111100000;
        bus.mode    = 1'b1;
        bus.div_val = 4'd3;
        for (int n = 1; n <= 22; n++) begin
            bus.inp1 = 4'b0100;
            bus.inp2 = (n <= 13 || n >= 16) ? 4'b0100 : 4'b0000;
            tick();
            exp_out = {1'b0, exp_seq[n], 2'b00};
            checks++;
            if (bus.out !== exp_out) begin
                errors++;
                $display("FAIL divide n=%0d out=%b expected=%b", n, bus.out, exp_out);
            end
        end
        $display("test_divide done");
    endtask

    // div_val=0 in mode 1 must reproduce the legacy trace (on lane 1).
    task automatic test_div_zero();
        logic [8:1] exp_seq;
        logic [3:0] exp_out;
        do_reset();
        exp_seq = 8'b00010100;
        bus.mode    = 1'b1;
        bus.div_val = 4'd0;
        for (int n = 1; n <= 8; n++) begin
            bus.inp1 = 4'b0010;
            bus.inp2 = (n <= 4) ? 4'b0010 : 4'b0000;
            tick();
            exp_out = {2'b00, exp_seq[n], 1'b0};
            checks++;
            if (bus.out !== exp_out) begin
                errors++;
                $display("FAIL div_zero n=%0d out=%b expected=%b", n, bus.out, exp_out);
            end
        end
        $display("test_div_zero done");
    endtask

    // div_val=15 on lane 3: state toggles at edges 16 and 32, so out is high for edges 18..33.
    task automatic test_div_max();
        logic [3:0] exp_out;
        do_reset();
        bus.mode    = 1'b1;
        bus.div_val = 4'd15;
        bus.inp1    = 4'b1000;
        bus.inp2    = 4'b1000;
        for (int n = 1; n <= 34; n++) begin
            tick();
            exp_out = (n >= 18 && n <= 33) ? 4'b1000 : 4'b0000;
            checks++;
            if (bus.out !== exp_out) begin
                errors++;
                $display("FAIL div_max n=%0d out=%b expected=%b", n, bus.out, exp_out);
            end
        end
        $display("test_div_max done");
    endtask

    // div_val 7 -> 2 while cnt=5 (after edge 5): toggle on edge 6, out high from edge 8.
    task automatic test_div_lower();
        logic [3:0] exp_out;
        do_reset();
        bus.mode    = 1'b1;
        bus.div_val = 4'd7;
        bus.inp1    = 4'b0001;
        bus.inp2    = 4'b0001;
        for (int n = 1; n <= 9; n++) begin
            if (n == 6) bus.div_val = 4'd2;
            tick();
            exp_out = (n >= 8) ? 4'b0001 : 4'b0000;
            checks++;
            if (bus.out !== exp_out) begin
                errors++;
                $display("FAIL div_lower n=%0d out=%b expected=%b", n, bus.out, exp_out);
            end
        end
        $display("test_div_lower done");
    endtask

    // Mode 0 for edge 1 (state=1), then mode 1 with div_val=1.
    task automatic test_mode_switch();
        logic [10:1] exp_seq;
        logic [3:0]  exp_out;
        do_reset();
        exp_seq = 10'b0011001100;
        bus.inp1    = 4'b0001;
        bus.inp2    = 4'b0001;
        bus.div_val = 4'd1;
        for (int n = 1; n <= 10; n++) begin
            bus.mode = (n >= 2);
            tick();
            exp_out = {3'b000, exp_seq[n]};
            checks++;
            if (bus.out !== exp_out) begin
                errors++;
                $display("FAIL mode_switch n=%0d out=%b expected=%b", n, bus.out, exp_out);
            end
        end
        $display("test_mode_switch done");
    endtask

`ifdef SIMPLE_TOGGLE_ARRAY_EVCNT_EN
    task automatic test_evcnt();
        do_reset();
        bus.inp1 = 4'hF;
        bus.inp2 = 4'hF;
        // All lanes rise on odd edges.
        repeat (5) tick();
        checks++;
        if (bus.evcnt !== 16'd12) begin
            errors++;
            $display("FAIL evcnt_three_rises evcnt=%0d expected=%0d", bus.evcnt, 12);
        end
        tick();
        checks++;
        if (bus.evcnt !== 16'd12) begin
            errors++;
            $display("FAIL evcnt_fall evcnt=%0d expected=%0d", bus.evcnt, 12);
        end
        bus.evcnt_clr = 1'b1;
        tick();
        bus.evcnt_clr = 1'b0;
        checks++;
        if (bus.evcnt !== 16'd0) begin
            errors++;
            $display("FAIL evcnt_clr_wins evcnt=%0d expected=%0d", bus.evcnt, 0);
        end
        repeat (2) tick();
        checks++;
        if (bus.evcnt !== 16'd4) begin
            errors++;
            $display("FAIL evcnt_after_clr evcnt=%0d expected=%0d", bus.evcnt, 4);
        end
        repeat (32800) tick();
        checks++;
        if (bus.evcnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL evcnt_saturate evcnt=%h expected=%h", bus.evcnt, 16'hFFFF);
        end
        repeat (4) tick();
        checks++;
        if (bus.evcnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL evcnt_hold_sat evcnt=%h expected=%h", bus.evcnt, 16'hFFFF);
        end
        $display("test_evcnt done");
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_legacy();
        test_divide();
        test_div_zero();
        test_div_max();
        test_div_lower();
        test_mode_switch();
`ifdef SIMPLE_TOGGLE_ARRAY_EVCNT_EN
        test_evcnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
